// File: rtl/reg_write_demux.sv
// reg_write_demux
//
// Write-side demultiplexer for a 32-entry register bank. One write per cycle
// goes to the addressed register, and a registered one-hot strobe reports that
// write for the following cycle. A Clear pulse starts a 32-cycle sequential
// sweep that zeroes the registers one at a time. Writes are refused while the
// sweep runs.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   WrValid       write request valid
//   WrReady       write can be accepted this cycle (combinational)
//   WrAddr        target register index 0..31
//   WrData        write data, WIDTH bits
//   Clear         single-cycle request to start a clear sweep
//   Busy          clear sweep in progress
//   Reg00..Reg31  current register contents (read-mux feed)
//   WrStrobe      one-hot of the register written in the previous cycle

module reg_write_demux #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WrValid,
    output logic             WrReady,
    input  logic [4:0]       WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             Clear,
    output logic             Busy,
    output logic [WIDTH-1:0] Reg00,
    output logic [WIDTH-1:0] Reg01,
    output logic [WIDTH-1:0] Reg02,
    output logic [WIDTH-1:0] Reg03,
    output logic [WIDTH-1:0] Reg04,
    output logic [WIDTH-1:0] Reg05,
    output logic [WIDTH-1:0] Reg06,
    output logic [WIDTH-1:0] Reg07,
    output logic [WIDTH-1:0] Reg08,
    output logic [WIDTH-1:0] Reg09,
    output logic [WIDTH-1:0] Reg10,
    output logic [WIDTH-1:0] Reg11,
    output logic [WIDTH-1:0] Reg12,
    output logic [WIDTH-1:0] Reg13,
    output logic [WIDTH-1:0] Reg14,
    output logic [WIDTH-1:0] Reg15,
    output logic [WIDTH-1:0] Reg16,
    output logic [WIDTH-1:0] Reg17,
    output logic [WIDTH-1:0] Reg18,
    output logic [WIDTH-1:0] Reg19,
    output logic [WIDTH-1:0] Reg20,
    output logic [WIDTH-1:0] Reg21,
    output logic [WIDTH-1:0] Reg22,
    output logic [WIDTH-1:0] Reg23,
    output logic [WIDTH-1:0] Reg24,
    output logic [WIDTH-1:0] Reg25,
    output logic [WIDTH-1:0] Reg26,
    output logic [WIDTH-1:0] Reg27,
    output logic [WIDTH-1:0] Reg28,
    output logic [WIDTH-1:0] Reg29,
    output logic [WIDTH-1:0] Reg30,
    output logic [WIDTH-1:0] Reg31,
    output logic [31:0]      WrStrobe
);

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [31:0]      strobe_q, strobe_d;
    logic             wr_accept;

    // Gating with rst_n keeps the handshake closed while reset is held, so a
    // source never sees a write as taken during reset.
    assign WrReady   = rst_n & (state_q == StIdle) & ~Clear;
    assign wr_accept = WrValid & WrReady;
    assign Busy      = (state_q == StClear);
    assign WrStrobe  = strobe_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        strobe_d = '0;
        unique case (state_q)
            StIdle: begin
                // Clear wins over a same-cycle write; WrReady is already low.
                if (Clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else if (wr_accept) begin
                    strobe_d = 32'd1 << WrAddr;
                    // Register 0 write is still strobed, only the store is dropped.
                    if (!(ZERO_REG && (WrAddr == 5'd0))) begin
                        regs_d[WrAddr] = WrData;
                    end
                end
            end
            StClear: begin
                // Clear is ignored here: the sweep always runs its full 32 cycles.
                regs_d[cnt_q] = '0;
                cnt_d         = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            strobe_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            regs_q   <= regs_d;
        end
    end

    assign Reg00 = regs_q[0];
    assign Reg01 = regs_q[1];
    assign Reg02 = regs_q[2];
    assign Reg03 = regs_q[3];
    assign Reg04 = regs_q[4];
    assign Reg05 = regs_q[5];
    assign Reg06 = regs_q[6];
    assign Reg07 = regs_q[7];
    assign Reg08 = regs_q[8];
    assign Reg09 = regs_q[9];
    assign Reg10 = regs_q[10];
    assign Reg11 = regs_q[11];
    assign Reg12 = regs_q[12];
    assign Reg13 = regs_q[13];
    assign Reg14 = regs_q[14];
    assign Reg15 = regs_q[15];
    assign Reg16 = regs_q[16];
    assign Reg17 = regs_q[17];
    assign Reg18 = regs_q[18];
    assign Reg19 = regs_q[19];
    assign Reg20 = regs_q[20];
    assign Reg21 = regs_q[21];
    assign Reg22 = regs_q[22];
    assign Reg23 = regs_q[23];
    assign Reg24 = regs_q[24];
    assign Reg25 = regs_q[25];
    assign Reg26 = regs_q[26];
    assign Reg27 = regs_q[27];
    assign Reg28 = regs_q[28];
    assign Reg29 = regs_q[29];
    assign Reg30 = regs_q[30];
    assign Reg31 = regs_q[31];

endmodule

// File: tb/tb_reg_write_demux.sv
// Self-checking bench for reg_write_demux (WIDTH=32, ZERO_REG=1).
// Directed steps drive one cycle each; the expected strobe for every cycle is
// queued when driven and popped after the edge, while a small behavioural
// model of the bank and sweep supplies expected register and Busy values.

module tb_reg_write_demux;

    localparam int unsigned W = 32;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic         WrValid = 1'b0;
    logic [4:0]   WrAddr  = '0;
    logic [W-1:0] WrData  = '0;
    logic         Clear   = 1'b0;
    logic         WrReady;
    logic         Busy;
    logic [31:0]  WrStrobe;
    logic [W-1:0] dut_reg [32];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0] m_regs [32];
    logic         m_busy;
    logic [4:0]   m_cnt;
    logic [31:0]  sb_q [$];

    always #5 clk = ~clk;

    reg_write_demux #(
        .WIDTH    (W),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WrValid  (WrValid),
        .WrReady  (WrReady),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Clear    (Clear),
        .Busy     (Busy),
        .Reg00    (dut_reg[0]),
        .Reg01    (dut_reg[1]),
        .Reg02    (dut_reg[2]),
        .Reg03    (dut_reg[3]),
        .Reg04    (dut_reg[4]),
        .Reg05    (dut_reg[5]),
        .Reg06    (dut_reg[6]),
        .Reg07    (dut_reg[7]),
        .Reg08    (dut_reg[8]),
        .Reg09    (dut_reg[9]),
        .Reg10    (dut_reg[10]),
        .Reg11    (dut_reg[11]),
        .Reg12    (dut_reg[12]),
        .Reg13    (dut_reg[13]),
        .Reg14    (dut_reg[14]),
        .Reg15    (dut_reg[15]),
        .Reg16    (dut_reg[16]),
        .Reg17    (dut_reg[17]),
        .Reg18    (dut_reg[18]),
        .Reg19    (dut_reg[19]),
        .Reg20    (dut_reg[20]),
        .Reg21    (dut_reg[21]),
        .Reg22    (dut_reg[22]),
        .Reg23    (dut_reg[23]),
        .Reg24    (dut_reg[24]),
        .Reg25    (dut_reg[25]),
        .Reg26    (dut_reg[26]),
        .Reg27    (dut_reg[27]),
        .Reg28    (dut_reg[28]),
        .Reg29    (dut_reg[29]),
        .Reg30    (dut_reg[30]),
        .Reg31    (dut_reg[31]),
        .WrStrobe (WrStrobe)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s_reg%0d", tag, i), dut_reg[i], m_regs[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
        end
        m_busy = 1'b0;
        m_cnt  = '0;
        sb_q.delete();
    endtask

    // One clock cycle: drive, check WrReady, update model, clock, compare.
    task automatic step(input logic v, input logic [4:0] a, input logic [W-1:0] d,
                        input logic c);
        logic [31:0] exp_s;
        WrValid = v;
        WrAddr  = a;
        WrData  = d;
        Clear   = c;
        #1;
        check("WrReady", WrReady, !m_busy && !c);
        exp_s = '0;
        if (!m_busy) begin
            if (c) begin
                m_busy = 1'b1;
                m_cnt  = '0;
            end else if (v) begin
                exp_s = 32'd1 << a;
                if (a != 5'd0) m_regs[a] = d;
            end
        end else begin
            m_regs[m_cnt] = '0;
            if (m_cnt == 5'd31) m_busy = 1'b0;
            m_cnt = m_cnt + 5'd1;
        end
        sb_q.push_back(exp_s);
        @(posedge clk);
        #1;
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) check("WrStrobe", WrStrobe, sb_q.pop_front());
        check("Busy", Busy, m_busy);
        check_regs("step");
    endtask

    initial begin
        int busy_cnt;
        model_reset();

        // Reset: asynchronous assertion, writes during reset dropped
        WrValid = 1'b1;
        WrAddr  = 5'd3;
        WrData  = 32'h5;
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", WrReady, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_strobe", WrStrobe, 32'h0);
        check_regs("rst");
        @(posedge clk);
        #1;
        check("rst_edge_strobe", WrStrobe, 32'h0);
        check("rst_edge_reg3", dut_reg[3], 32'h0);
        #5 rst_n = 1'b1;
        WrValid = 1'b0;
        @(posedge clk);
        #1;

        // Basic write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        check("basic_reg05", dut_reg[5], 32'hDEADBEEF);
        check("basic_strobe", WrStrobe, 32'h0000_0020);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Zero register
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        check("zero_reg00", dut_reg[0], 32'h0);
        check("zero_strobe", WrStrobe, 32'h0000_0001);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Back-to-back
        step(1'b1, 5'd31, 32'd1, 1'b0);
        step(1'b1, 5'd1, 32'd2, 1'b0);
        step(1'b1, 5'd31, 32'd3, 1'b0);
        check("b2b_reg31", dut_reg[31], 32'd3);
        check("b2b_reg01", dut_reg[1], 32'd2);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // A few random writes, some with WrValid low
        for (int i = 0; i < 12; i++) begin
            step(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom, 1'b0);
        end

        // Fill with A5, then clear sweep with WrValid held high
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 32'hA5A5A5A5, 1'b0);
        end
        step(1'b0, 5'd0, 32'h0, 1'b1);
        busy_cnt = Busy ? 1 : 0;
        for (int k = 0; k < 40 && Busy; k++) begin
            step(1'b1, 5'(k), 32'h1234_0000 | k, 1'b0);
            if (Busy) busy_cnt++;
        end
        check("sweep_len", busy_cnt, 32);
        check("sweep_busy_end", Busy, 1'b0);

        // Clear/write collision, then re-Clear at sweep cycle 10
        step(1'b1, 5'd7, 32'h77, 1'b0);
        step(1'b1, 5'd7, 32'd9, 1'b1);
        check("coll_reg07", dut_reg[7], 32'h77);
        busy_cnt = Busy ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0);
            if (Busy) busy_cnt++;
        end
        step(1'b0, 5'd0, 32'h0, 1'b1);
        if (Busy) busy_cnt++;
        for (int k = 0; k < 40 && Busy; k++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0);
            if (Busy) busy_cnt++;
        end
        check("reclear_len", busy_cnt, 32);

        // Reset mid-sweep at sweep cycle 15
        step(1'b1, 5'd10, 32'hABC, 1'b0);
        step(1'b1, 5'd20, 32'hDEF, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 5'd0, 32'h0, 1'b0);
        end
        check("pre_rst_reg20", dut_reg[20], 32'hDEF);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", Busy, 1'b0);
        check("mid_rst_ready", WrReady, 1'b0);
        check("mid_rst_strobe", WrStrobe, 32'h0);
        check_regs("mid_rst");
        #2 rst_n = 1'b1;
        step(1'b1, 5'd3, 32'h33, 1'b0);
        check("post_rst_reg03", dut_reg[3], 32'h33);
        check("post_rst_strobe", WrStrobe, 32'h0000_0008);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
